// File: rtl/scu_abus_pkg.sv
// Shared types and chip-select decode for the SCU A-bus initiator.
package scu_abus_pkg;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE} state_t;
  typedef enum logic [1:0] {CS_NONE, CS_0, CS_1, CS_2} cs_sel_t;

  localparam logic [1:0] CS0_MATCH = 2'b01;      // REQ_A[26:25]
  localparam logic [2:0] CS1_MATCH = 3'b100;     // REQ_A[26:24]
  localparam logic [6:0] CS2_MATCH = 7'b1011000; // REQ_A[26:20]

  function automatic cs_sel_t abus_decode(input logic [26:0] a);
    if (a[26:25] == CS0_MATCH) return CS_0;
    if (a[26:24] == CS1_MATCH) return CS_1;
    if (a[26:20] == CS2_MATCH) return CS_2;
    return CS_NONE;
  endfunction

endpackage

// File: rtl/scu_abus_timer.sv
// Loadable down-counter advancing on a clock enable; done while the count is zero.
module scu_abus_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ce,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                    cnt_d = load_val;
    else if (ce && cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign done = (cnt_q == '0);

endmodule

// File: rtl/scu_abus_master.sv
// SCU A-bus initiator: one request -> one or two 16-bit strobe cycles with AWAIT_N stretching.
// Define ABUS_TIMEOUT_EN to add the stretched-strobe watchdog (abort with REQ_ERR).
module scu_abus_master
  import scu_abus_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1,
  parameter int TMO_CYC    = 1023
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        REQ_RD,
  input  logic        REQ_WR,
  input  logic [26:0] REQ_A,
  input  logic        REQ_SZ,
  input  logic [1:0]  REQ_BE,
  input  logic [31:0] REQ_DI,
  output logic [31:0] REQ_DO,
  output logic        REQ_ACK,
  output logic        REQ_ERR,
  output logic        READY,
  output logic [25:0] AA,
  output logic [15:0] ADO,
  input  logic [15:0] ADI,
  output logic        ACS0_N,
  output logic        ACS1_N,
  output logic        ACS2_N,
  output logic        ARD_N,
  output logic        AWRU_N,
  output logic        AWRL_N,
  input  logic        AWAIT_N
);

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
  localparam logic [3:0] HOLD_LD   = (HOLD_CYC > 0) ? 4'(HOLD_CYC - 1) : 4'd0;

  state_t      state_q, state_d;
  cs_sel_t     cs_q, cs_d, cs_dec;
  logic        wr_q, wr_d, sz_q, sz_d, half_q, half_d, err_q, err_d;
  logic [1:0]  be_q, be_d;
  logic [31:0] wdat_q, wdat_d, do_q, do_d;
  logic [25:0] aa_q, aa_d;
  logic [15:0] ado_q, ado_d;
  logic        tmr_load, tmr_done, wdt_load, adv, first_hi, cs_act, a0_unused;
  logic [3:0]  tmr_val;

  assign cs_dec    = abus_decode(REQ_A);
  assign first_hi  = sz_q && !half_q;
  assign a0_unused = REQ_A[0];

  scu_abus_timer #(.W(4)) u_tmr (
    .clk(CLK), .rst_n(RST_N), .ce(CE_R), .load(tmr_load), .load_val(tmr_val), .done(tmr_done)
  );

`ifdef ABUS_TIMEOUT_EN
  localparam int WW = $clog2(TMO_CYC + 1);
  logic wdt_ce, wdt_done;
  // Only ticks where the strobe is being held purely by AWAIT_N count toward the watchdog.
  assign wdt_ce = CE_R && (state_q == S_STROBE) && tmr_done && !AWAIT_N;
  scu_abus_timer #(.W(WW)) u_wdt (
    .clk(CLK), .rst_n(RST_N), .ce(wdt_ce), .load(wdt_load), .load_val(WW'(TMO_CYC - 1)), .done(wdt_done)
  );
`else
  logic wdt_unused;
  assign wdt_unused = wdt_load ^ (TMO_CYC != 0);
`endif

  always_comb begin
    state_d = state_q; cs_d = cs_q; wr_d = wr_q; sz_d = sz_q; half_d = half_q;
    be_d = be_q; wdat_d = wdat_q; aa_d = aa_q; ado_d = ado_q; do_d = do_q; err_d = err_q;
    tmr_load = 1'b0; tmr_val = '0; wdt_load = 1'b0; adv = 1'b0;
    unique case (state_q)
      S_IDLE: if (REQ_RD || REQ_WR) begin
        wr_d   = REQ_WR;
        sz_d   = REQ_SZ;
        be_d   = REQ_SZ ? 2'b11 : REQ_BE;
        wdat_d = REQ_DI;
        half_d = 1'b0;
        cs_d   = cs_dec;
        aa_d   = {1'b0, REQ_A[24:1], 1'b0}; // window-relative address
        if (cs_dec == CS_NONE) begin
          do_d = '1; err_d = 1'b1; state_d = S_DONE;
        end else begin
          do_d = '0; err_d = 1'b0; state_d = S_SETUP;
          tmr_load = 1'b1; tmr_val = SETUP_LD;
        end
      end
      S_SETUP: begin
        // Exit tick also loads ADO so data is valid at strobe even without an intervening CE_F.
        if (wr_q && (CE_F || (CE_R && tmr_done)))
          ado_d = first_hi ? wdat_q[31:16] : wdat_q[15:0];
        if (CE_R && tmr_done) begin
          state_d = S_STROBE; tmr_load = 1'b1; tmr_val = STROBE_LD; wdt_load = 1'b1;
        end
      end
      S_STROBE: if (CE_R && tmr_done) begin
        if (AWAIT_N) begin
          if (!wr_q) begin
            if (first_hi) do_d[31:16] = ADI;
            else          do_d[15:0]  = ADI;
          end
          if (HOLD_CYC == 0) adv = 1'b1;
          else begin
            state_d = S_HOLD; tmr_load = 1'b1; tmr_val = HOLD_LD;
          end
        end
`ifdef ABUS_TIMEOUT_EN
        else if (wdt_done) begin
          do_d = '1; err_d = 1'b1; state_d = S_DONE;
        end
`endif
      end
      S_HOLD:  if (CE_R && tmr_done) adv = 1'b1;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (adv) begin
      if (first_hi) begin
        half_d = 1'b1; aa_d = aa_q + 26'd2; state_d = S_SETUP;
        tmr_load = 1'b1; tmr_val = SETUP_LD;
      end else begin
        state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state_q <= S_IDLE; cs_q <= CS_NONE; wr_q <= 1'b0; sz_q <= 1'b0; half_q <= 1'b0;
      be_q <= 2'b00; wdat_q <= '0; aa_q <= '0; ado_q <= '0; do_q <= '0; err_q <= 1'b0;
    end else begin
      state_q <= state_d; cs_q <= cs_d; wr_q <= wr_d; sz_q <= sz_d; half_q <= half_d;
      be_q <= be_d; wdat_q <= wdat_d; aa_q <= aa_d; ado_q <= ado_d; do_q <= do_d; err_q <= err_d;
    end

  // CS spans SETUP..HOLD of both halves; decoded from state so reset releases it at once.
  assign cs_act  = (state_q == S_SETUP) || (state_q == S_STROBE) || (state_q == S_HOLD);
  assign ACS0_N  = !(cs_act && cs_q == CS_0);
  assign ACS1_N  = !(cs_act && cs_q == CS_1);
  assign ACS2_N  = !(cs_act && cs_q == CS_2);
  assign ARD_N   = !(state_q == S_STROBE && !wr_q);
  assign AWRU_N  = !(state_q == S_STROBE && wr_q && be_q[1]);
  assign AWRL_N  = !(state_q == S_STROBE && wr_q && be_q[0]);
  assign AA      = aa_q;
  assign ADO     = ado_q;
  assign REQ_DO  = do_q;
  assign REQ_ACK = (state_q == S_DONE);
  assign REQ_ERR = (state_q == S_DONE) && err_q;
  assign READY   = (state_q == S_IDLE);

endmodule

// File: tb/tb_scu_abus_master.sv
// Scoreboard bench for scu_abus_master: expected completions queued at issue, checked at REQ_ACK.
module tb_scu_abus_master;

  logic        CLK = 1'b0, RST_N = 1'b0, CE_R = 1'b0, CE_F = 1'b1;
  logic        REQ_RD = 1'b0, REQ_WR = 1'b0, REQ_SZ = 1'b0;
  logic [26:0] REQ_A = '0;
  logic [1:0]  REQ_BE = 2'b11;
  logic [31:0] REQ_DI = '0;
  logic [31:0] REQ_DO;
  logic        REQ_ACK, REQ_ERR, READY;
  logic [25:0] AA;
  logic [15:0] ADO, ADI;
  logic [15:0] adi_man = 16'h0000;
  logic        rsp_auto = 1'b0;
  logic        ACS0_N, ACS1_N, ACS2_N, ARD_N, AWRU_N, AWRL_N;
  logic        AWAIT_N = 1'b1;

  int checks = 0, failures = 0;

  typedef struct { logic [31:0] dout; logic err; logic chk_do; } exp_t;
  typedef struct { logic [25:0] aa; logic [15:0] ado; logic [2:0] csn; logic rd, wu, wl; int ticks; } seg_t;
  exp_t exp_q[$];
  seg_t seg_q[$];
  int   cs_fall = 0;
  logic cs_prev = 1'b0, in_str = 1'b0;

  // Auto responder returns a function of the address so each half is distinguishable.
  function automatic logic [15:0] rsp_model(input logic [25:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction
  assign ADI = rsp_auto ? rsp_model(AA) : adi_man;

  scu_abus_master dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .REQ_RD(REQ_RD), .REQ_WR(REQ_WR),
    .REQ_A(REQ_A), .REQ_SZ(REQ_SZ), .REQ_BE(REQ_BE), .REQ_DI(REQ_DI), .REQ_DO(REQ_DO),
    .REQ_ACK(REQ_ACK), .REQ_ERR(REQ_ERR), .READY(READY), .AA(AA), .ADO(ADO), .ADI(ADI),
    .ACS0_N(ACS0_N), .ACS1_N(ACS1_N), .ACS2_N(ACS2_N), .ARD_N(ARD_N), .AWRU_N(AWRU_N),
    .AWRL_N(AWRL_N), .AWAIT_N(AWAIT_N)
  );

  always #5 CLK = ~CLK;
  initial forever begin
    @(posedge CLK); #1;
    CE_R = ~CE_R; CE_F = ~CE_R;
  end

  // Bus monitor: one record per strobe assertion, counting CE_R ticks while low.
  always @(negedge CLK) begin
    logic strb, csl;
    seg_t s;
    strb = !ARD_N || !AWRU_N || !AWRL_N;
    csl  = !ACS0_N || !ACS1_N || !ACS2_N;
    if (csl && !cs_prev) cs_fall = cs_fall + 1;
    cs_prev = csl;
    if (strb) begin
      if (!in_str) begin
        s.aa = AA; s.ado = ADO; s.csn = {ACS2_N, ACS1_N, ACS0_N};
        s.rd = !ARD_N; s.wu = !AWRU_N; s.wl = !AWRL_N; s.ticks = 0;
        seg_q.push_back(s);
      end
      if (CE_R) seg_q[seg_q.size()-1].ticks = seg_q[seg_q.size()-1].ticks + 1;
    end
    in_str = strb;
  end

  task automatic clr_mon();
    seg_q.delete();
    cs_fall = 0;
  endtask

  task automatic drive_req(input logic rd, input logic wr, input logic [26:0] a, input logic sz,
                           input logic [1:0] be, input logic [31:0] di, input bit push,
                           input logic [31:0] edo, input logic eerr, input logic chk);
    int n;
    exp_t e;
    n = 0;
    @(posedge CLK); #1;
    while (!READY && n < 300) begin @(posedge CLK); #1; n++; end
    if (n >= 300) begin
      checks++; failures++;
      $display("FAIL issue_ready: READY still %b after %0d cycles", READY, n);
    end
    REQ_RD = rd; REQ_WR = wr; REQ_A = a; REQ_SZ = sz; REQ_BE = be; REQ_DI = di;
    @(posedge CLK); #1;
    REQ_RD = 1'b0; REQ_WR = 1'b0;
    if (push) begin
      e.dout = edo; e.err = eerr; e.chk_do = chk;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_ack(output int n, output bit got);
    got = 1'b0; n = 0;
    while (!got && n < 400) begin @(negedge CLK); n++; got = REQ_ACK; end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    checks++; if ({ARD_N, AWRU_N, AWRL_N, ACS0_N, ACS1_N, ACS2_N} !== 6'b111111) begin failures++;
      $display("FAIL reset_strobes: got %b expected 111111", {ARD_N, AWRU_N, AWRL_N, ACS0_N, ACS1_N, ACS2_N}); end
    checks++; if (AA !== 26'h0) begin failures++; $display("FAIL reset_aa: got %h expected 0", AA); end
    checks++; if (ADO !== 16'h0) begin failures++; $display("FAIL reset_ado: got %h expected 0", ADO); end
    checks++; if (REQ_DO !== 32'h0) begin failures++; $display("FAIL reset_do: got %h expected 0", REQ_DO); end
    checks++; if ({REQ_ACK, REQ_ERR, READY} !== 3'b001) begin failures++;
      $display("FAIL reset_ctl: ack/err/ready got %b expected 001", {REQ_ACK, REQ_ERR, READY}); end
    @(posedge CLK); #1; RST_N = 1'b1;
  endtask

  task automatic test_rd16();
    int n; bit got; exp_t e;
    AWAIT_N = 1'b1; rsp_auto = 1'b0; adi_man = 16'h1234;
    clr_mon();
    drive_req(1'b1, 1'b0, 27'h2000010, 1'b0, 2'b11, 32'h0, 1'b1, 32'h0000_1234, 1'b0, 1'b1);
    wait_ack(n, got);
    checks++; if (!got) begin failures++; $display("FAIL rd16_ack: no REQ_ACK in %0d cycles", n); end
    e = exp_q.pop_front();
    checks++; if (REQ_DO !== e.dout) begin failures++; $display("FAIL rd16_do: got %h expected %h", REQ_DO, e.dout); end
    checks++; if (REQ_ERR !== e.err) begin failures++; $display("FAIL rd16_err: got %b expected %b", REQ_ERR, e.err); end
    checks++; if (READY !== 1'b0) begin failures++; $display("FAIL rd16_ready_ack: got %b expected 0", READY); end
    @(negedge CLK);
    checks++; if ({REQ_ACK, READY} !== 2'b01) begin failures++;
      $display("FAIL rd16_ack_pulse: ack/ready got %b expected 01", {REQ_ACK, READY}); end
    checks++; if (seg_q.size() != 1) begin failures++; $display("FAIL rd16_segs: got %0d expected 1", seg_q.size()); end
    if (seg_q.size() >= 1) begin
      checks++; if (seg_q[0].aa !== 26'h0000010) begin failures++; $display("FAIL rd16_aa: got %h expected 0000010", seg_q[0].aa); end
      checks++; if (seg_q[0].csn !== 3'b110) begin failures++; $display("FAIL rd16_cs: got %b expected 110", seg_q[0].csn); end
      checks++; if ({seg_q[0].rd, seg_q[0].wu, seg_q[0].wl} !== 3'b100) begin failures++;
        $display("FAIL rd16_strobe: got %b expected 100", {seg_q[0].rd, seg_q[0].wu, seg_q[0].wl}); end
      checks++; if (seg_q[0].ticks != 3) begin failures++; $display("FAIL rd16_ticks: got %0d expected 3", seg_q[0].ticks); end
    end
  endtask

  task automatic test_wr32();
    int n; bit got; exp_t e;
    clr_mon();
    drive_req(1'b0, 1'b1, 27'h4000100, 1'b1, 2'b01, 32'hAABB_CCDD, 1'b1, 32'h0, 1'b0, 1'b0);
    wait_ack(n, got);
    checks++; if (!got) begin failures++; $display("FAIL wr32_ack: no REQ_ACK in %0d cycles", n); end
    e = exp_q.pop_front();
    checks++; if (REQ_ERR !== e.err) begin failures++; $display("FAIL wr32_err: got %b expected %b", REQ_ERR, e.err); end
    checks++; if (seg_q.size() != 2) begin failures++; $display("FAIL wr32_segs: got %0d expected 2", seg_q.size()); end
    checks++; if (cs_fall != 1) begin failures++; $display("FAIL wr32_cs_once: got %0d CS assertions expected 1", cs_fall); end
    if (seg_q.size() >= 2) begin
      checks++; if ({seg_q[0].aa, seg_q[0].ado} !== {26'h100, 16'hAABB}) begin failures++;
        $display("FAIL wr32_half0: aa/ado got %h/%h expected 0000100/aabb", seg_q[0].aa, seg_q[0].ado); end
      checks++; if ({seg_q[1].aa, seg_q[1].ado} !== {26'h102, 16'hCCDD}) begin failures++;
        $display("FAIL wr32_half1: aa/ado got %h/%h expected 0000102/ccdd", seg_q[1].aa, seg_q[1].ado); end
      checks++; if ({seg_q[0].rd, seg_q[0].wu, seg_q[0].wl, seg_q[1].rd, seg_q[1].wu, seg_q[1].wl} !== 6'b011011) begin failures++;
        $display("FAIL wr32_strobes: got %b expected 011011", {seg_q[0].rd, seg_q[0].wu, seg_q[0].wl, seg_q[1].rd, seg_q[1].wu, seg_q[1].wl}); end
      checks++; if (seg_q[0].csn !== 3'b101) begin failures++; $display("FAIL wr32_cs: got %b expected 101", seg_q[0].csn); end
    end
  endtask

  task automatic test_wr16_be();
    int n; bit got; exp_t e;
    clr_mon();
    drive_req(1'b0, 1'b1, 27'h5800000, 1'b0, 2'b10, 32'h0000_5A5A, 1'b1, 32'h0, 1'b0, 1'b0);
    wait_ack(n, got);
    checks++; if (!got) begin failures++; $display("FAIL wr16_ack: no REQ_ACK in %0d cycles", n); end
    e = exp_q.pop_front();
    checks++; if (REQ_ERR !== e.err) begin failures++; $display("FAIL wr16_err: got %b expected %b", REQ_ERR, e.err); end
    checks++; if (seg_q.size() != 1) begin failures++; $display("FAIL wr16_segs: got %0d expected 1", seg_q.size()); end
    if (seg_q.size() >= 1) begin
      checks++; if ({seg_q[0].rd, seg_q[0].wu, seg_q[0].wl} !== 3'b010) begin failures++;
        $display("FAIL wr16_strobe: got %b expected 010", {seg_q[0].rd, seg_q[0].wu, seg_q[0].wl}); end
      checks++; if (seg_q[0].csn !== 3'b011) begin failures++; $display("FAIL wr16_cs: got %b expected 011", seg_q[0].csn); end
      checks++; if (seg_q[0].ado !== 16'h5A5A) begin failures++; $display("FAIL wr16_ado: got %h expected 5a5a", seg_q[0].ado); end
    end
  endtask

  task automatic test_stretch();
    int n, k; bit got; exp_t e;
    clr_mon();
    AWAIT_N = 1'b0; adi_man = 16'hDEAD;
    drive_req(1'b1, 1'b0, 27'h2000020, 1'b0, 2'b11, 32'h0, 1'b1, 32'h0000_BEEF, 1'b0, 1'b1);
    n = 0; k = 0;
    while (n < 20 && k < 300) begin @(negedge CLK); k++; if (!ARD_N && CE_R) n++; end
    checks++; if (n != 20) begin failures++; $display("FAIL stretch_low: got %0d strobe ticks expected 20", n); end
    @(posedge CLK); #1;
    AWAIT_N = 1'b1; adi_man = 16'hBEEF;
    wait_ack(n, got);
    checks++; if (!got) begin failures++; $display("FAIL stretch_ack: no REQ_ACK in %0d cycles", n); end
    e = exp_q.pop_front();
    checks++; if (REQ_DO !== e.dout) begin failures++; $display("FAIL stretch_do: got %h expected %h", REQ_DO, e.dout); end
    checks++; if (seg_q.size() != 1) begin failures++; $display("FAIL stretch_segs: got %0d expected 1", seg_q.size()); end
    if (seg_q.size() >= 1) begin
      checks++; if (seg_q[0].ticks != 21) begin failures++; $display("FAIL stretch_ticks: got %0d expected 21", seg_q[0].ticks); end
    end
  endtask

  task automatic test_unmapped();
    int n; bit got; exp_t e;
    clr_mon();
    drive_req(1'b1, 1'b0, 27'h6000000, 1'b0, 2'b11, 32'h0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_ack(n, got);
    checks++; if (!got || n != 1) begin failures++; $display("FAIL unmap_ack: got ack=%b after %0d cycles expected ack after 1", got, n); end
    e = exp_q.pop_front();
    checks++; if (REQ_DO !== e.dout) begin failures++; $display("FAIL unmap_do: got %h expected %h", REQ_DO, e.dout); end
    checks++; if (REQ_ERR !== e.err) begin failures++; $display("FAIL unmap_err: got %b expected %b", REQ_ERR, e.err); end
    checks++; if (seg_q.size() != 0 || cs_fall != 0) begin failures++;
      $display("FAIL unmap_bus: got %0d strobes %0d CS assertions expected 0/0", seg_q.size(), cs_fall); end
  endtask

  task automatic test_priority();
    int n, k, extra; bit got; exp_t e;
    clr_mon();
    drive_req(1'b1, 1'b1, 27'h2000080, 1'b0, 2'b11, 32'h0000_1357, 1'b1, 32'h0, 1'b0, 1'b0);
    k = 0;
    while (AWRL_N && k < 100) begin @(negedge CLK); k++; end
    @(posedge CLK); #1; REQ_RD = 1'b1;
    @(posedge CLK); #1; REQ_RD = 1'b0;
    wait_ack(n, got);
    checks++; if (!got) begin failures++; $display("FAIL prio_ack: no REQ_ACK in %0d cycles", n); end
    e = exp_q.pop_front();
    checks++; if (REQ_ERR !== e.err) begin failures++; $display("FAIL prio_err: got %b expected %b", REQ_ERR, e.err); end
    extra = 0;
    repeat (40) begin @(negedge CLK); if (REQ_ACK) extra++; end
    checks++; if (extra != 0 || seg_q.size() != 1) begin failures++;
      $display("FAIL prio_drop: got %0d extra acks %0d strobes expected 0/1", extra, seg_q.size()); end
    if (seg_q.size() >= 1) begin
      checks++; if ({seg_q[0].rd, seg_q[0].wu, seg_q[0].wl, seg_q[0].ado} !== {3'b011, 16'h1357}) begin failures++;
        $display("FAIL prio_write: strobes/ado got %b/%h expected 011/1357", {seg_q[0].rd, seg_q[0].wu, seg_q[0].wl}, seg_q[0].ado); end
    end
  endtask

  task automatic test_back_to_back();
    clr_mon();
    rsp_auto = 1'b1; AWAIT_N = 1'b1;
    fork
      begin
        drive_req(1'b1, 1'b0, 27'h2000200, 1'b1, 2'b11, 32'h0, 1'b1,
                  {rsp_model(26'h200), rsp_model(26'h202)}, 1'b0, 1'b1);
        drive_req(1'b1, 1'b0, 27'h2000300, 1'b0, 2'b11, 32'h0, 1'b1,
                  {16'h0000, rsp_model(26'h300)}, 1'b0, 1'b1);
      end
      begin
        for (int i = 0; i < 2; i++) begin
          int n; bit got; exp_t e;
          wait_ack(n, got);
          checks++; if (!got) begin failures++; $display("FAIL b2b_ack%0d: no REQ_ACK in %0d cycles", i, n); end
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++; if (REQ_DO !== e.dout || REQ_ERR !== e.err) begin failures++;
              $display("FAIL b2b_do%0d: do/err got %h/%b expected %h/%b", i, REQ_DO, REQ_ERR, e.dout, e.err); end
          end
        end
      end
    join
    checks++; if (seg_q.size() != 3) begin failures++; $display("FAIL b2b_segs: got %0d expected 3", seg_q.size()); end
    rsp_auto = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k, acks;
    clr_mon();
    AWAIT_N = 1'b0;
    drive_req(1'b1, 1'b0, 27'h2000040, 1'b0, 2'b11, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    k = 0;
    while (ARD_N && k < 100) begin @(negedge CLK); k++; end
    checks++; if (ARD_N !== 1'b0) begin failures++; $display("FAIL rstmid_strobe: ARD_N got %b expected 0 before reset", ARD_N); end
    #2 RST_N = 1'b0;
    #1;
    checks++; if ({ARD_N, ACS0_N, READY} !== 3'b111) begin failures++;
      $display("FAIL rstmid_release: ard/cs0/ready got %b expected 111", {ARD_N, ACS0_N, READY}); end
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1; AWAIT_N = 1'b1;
    acks = 0;
    repeat (30) begin @(negedge CLK); if (REQ_ACK) acks++; end
    checks++; if (acks != 0 || REQ_DO !== 32'h0) begin failures++;
      $display("FAIL rstmid_noack: got %0d acks do=%h expected 0 acks do=00000000", acks, REQ_DO); end
  endtask

  initial begin
    test_reset();
    test_rd16();
    test_wr32();
    test_wr16_be();
    test_stretch();
    test_unmapped();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
